// File: rtl/ibuf_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf_seq_ctrl_if
//  Description : Bundle of command, SRAM-read, buffer-write and status signals
//                between the tile scheduler, input SRAM, input buffer and the
//                ibuf_seq_ctrl sequencer. Names are from the sequencer's
//                point of view (i_ = into the sequencer, o_ = out of it).
//                STALL_CNT exists only when IBUF_SEQ_STALL_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ibuf_seq_ctrl_if #(
    parameter int AW = 8
);
    // Command side (tile scheduler)
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [3:0]    i_odst_cfg;
    logic          i_array_rdy;
    // Input SRAM read port
    logic          o_mem_re;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   i_mem_rdata;
    // Input buffer write port
    logic          o_load_en;
    logic [1:0]    o_icol;
    logic [31:0]   o_iword;
    // Array launch and status
    logic          o_start_calc;
    logic [3:0]    o_odst;
    logic          o_busy;
    logic          o_done;
`ifdef IBUF_SEQ_STALL_CNT_EN
    logic [15:0]   o_stall_cnt;
`endif

    // Environment side: scheduler, SRAM and buffer drive the sequencer inputs
    modport master (
        output i_start, i_base_addr, i_odst_cfg, i_array_rdy, i_mem_rdata,
        input  o_mem_re, o_mem_addr, o_load_en, o_icol, o_iword,
               o_start_calc, o_odst, o_busy, o_done
`ifdef IBUF_SEQ_STALL_CNT_EN
        , input o_stall_cnt
`endif
    );

    // Sequencer side
    modport slave (
        input  i_start, i_base_addr, i_odst_cfg, i_array_rdy, i_mem_rdata,
        output o_mem_re, o_mem_addr, o_load_en, o_icol, o_iword,
               o_start_calc, o_odst, o_busy, o_done
`ifdef IBUF_SEQ_STALL_CNT_EN
        , output o_stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/ibuf_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf_seq_ctrl
//  Description : Sequencer for the 4-column input buffer in front of the MAC
//                array. Fetches four SRAM words into buffer columns 0..3,
//                waits for the array, pulses START_CALC, drains the skew
//                pipeline and signals DONE. Forwards the latched ODST tag.
//                Optional feature macro: IBUF_SEQ_STALL_CNT_EN (adds a 16-bit
//                saturating count of array back-pressure cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module ibuf_seq_ctrl #(
    parameter int AW    = 8,    // SRAM word-address width (must match bus)
    parameter int DRAIN = 8,    // drain cycles after START_CALC, >= 1
    parameter int CW    = 4     // drain counter width, 2**CW > DRAIN
) (
    input  logic              clk,
    input  logic              rst_n,
    ibuf_seq_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LOADTAIL = 3'd2,
        S_WAITRDY  = 3'd3,
        S_CALC     = 3'd4,
        S_DRAIN    = 3'd5,
        S_FIN      = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_k;         // fetch index within the 4-word tile
    logic [AW-1:0] r_base;
    logic [3:0]    r_odst;
    logic [CW-1:0] r_cnt;
    logic          r_load_en;
    logic [1:0]    r_icol;
    logic          w_accept;

    assign w_accept = (r_state == S_IDLE) && bus.i_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-driven outputs.
    // LOADTAIL already checks ARRAY_RDY so that an array that is ready costs
    // no extra cycle: launch follows the last buffer write immediately.
    always_comb begin
        w_next           = r_state;
        bus.o_mem_re     = 1'b0;
        bus.o_mem_addr   = '0;
        bus.o_start_calc = 1'b0;
        bus.o_busy       = 1'b1;
        bus.o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.o_busy = 1'b0;
                if (bus.i_start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.o_mem_re   = 1'b1;
                bus.o_mem_addr = r_base + AW'(r_k);   // wraps mod 2**AW
                if (r_k == 2'd3) begin
                    w_next = S_LOADTAIL;
                end
            end
            S_LOADTAIL: begin
                w_next = bus.i_array_rdy ? S_CALC : S_WAITRDY;
            end
            S_WAITRDY: begin
                if (bus.i_array_rdy) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                bus.o_start_calc = 1'b1;
                w_next           = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                bus.o_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                bus.o_busy = 1'b0;
                w_next     = S_IDLE;
            end
        endcase
    end

    // Command latch, fetch index and drain counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
            r_odst <= 4'h0;
            r_k    <= 2'd0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_base <= bus.i_base_addr;
                r_odst <= bus.i_odst_cfg;
                r_k    <= 2'd0;
            end else if (r_state == S_FETCH) begin
                r_k <= r_k + 2'd1;
            end
            if (r_state == S_CALC) begin
                r_cnt <= CW'(DRAIN);
            end else if (r_state == S_DRAIN) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Buffer write pipeline: each read's data lands one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_en <= 1'b0;
            r_icol    <= 2'd0;
        end else begin
            r_load_en <= (r_state == S_FETCH);
            r_icol    <= r_k;
        end
    end

    assign bus.o_load_en = r_load_en;
    assign bus.o_icol    = r_icol;
    // Data passes straight from SRAM; forced to zero outside write cycles so
    // the buffer port is quiet in reset and idle.
    assign bus.o_iword   = r_load_en ? bus.i_mem_rdata : 32'h0;
    assign bus.o_odst    = r_odst;

`ifdef IBUF_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Back-pressure counter: every cycle the launch is held off by
    // ARRAY_RDY=0 (from the tail-write cycle onward), saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0;
        end else if (w_accept) begin
            r_stall_cnt <= 16'h0;
        end else if (((r_state == S_LOADTAIL) || (r_state == S_WAITRDY)) &&
                     !bus.i_array_rdy && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h1;
        end
    end

    assign bus.o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
